// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receive path: frame FSM states,
// scancode prefix bytes, frame geometry and the parity helper.
package ps2_pkg;

  // Receive FSM states, one per field of the device-to-host frame.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  // Prefix bytes that are folded into flags rather than reported as keys.
  localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;

  // Start + 8 data + parity + stop.
  localparam int PS2_FRAME_LEN = 11;
  localparam int PS2_DATA_BITS = PS2_FRAME_LEN - 3;

  // PS/2 uses odd parity: the data bits plus the parity bit hold an odd
  // number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizer, glitch filter and falling-edge strobe for one PS/2 line.
// The filtered level only follows the synchronized line once it has held a
// different value for FILTER_LEN consecutive clocks, so short spikes on the
// open-collector PS/2 clock never produce a strobe.
module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic line_raw,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    sync_q;
  logic          line_sync;
  logic          level_q;
  logic [CW-1:0] cnt_q;

  // Two-flop synchronizer; the idle PS/2 line is high, so reset to ones.
  always_ff @(posedge clock) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], line_raw};
  end

  assign line_sync = sync_q[1];

  // Count consecutive samples that disagree with the filtered level; commit
  // the new level on the FILTER_LEN-th one and flag a 1->0 commit as a fall.
  always_ff @(posedge clock) begin
    if (reset) begin
      level_q <= 1'b1;
      cnt_q   <= '0;
      fall    <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (line_sync == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= line_sync;
        cnt_q   <= '0;
        fall    <= level_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard_receiver.sv
// PS/2 keyboard receiver: turns device-to-host frames into key events for the
// game logic. E0 and F0 prefixes are folded into code_extended and
// code_released on the following scancode.
//
// Output protocol: code_valid is a one-cycle pulse with no back-pressure;
// code, code_extended and code_released change only in a code_valid cycle and
// hold until the next one. frame_error is a one-cycle pulse for a discarded
// frame and never coincides with code_valid.
module ps2_keyboard_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_extended,
  output logic       code_released,
  output logic       code_valid,
  output logic       frame_error,
  output logic [1:0] state_dbg
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES);
  localparam logic [2:0]    LAST_BIT     = 3'(PS2_DATA_BITS - 1);

  logic          fall;
  logic [1:0]    data_sync_q;
  logic          data_sync;

  ps2_state_t    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tcnt_q;
  logic          timeout;
  logic          byte_ok;
  logic          frame_bad;
  logic          pending_ext_q;
  logic          pending_rel_q;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clock_filter (
    .clock    (clock),
    .reset    (reset),
    .line_raw (ps2_clock),
    .fall     (fall)
  );

  // Bare two-flop synchronizer for the data pin; it is only looked at on a
  // filtered clock fall, long after it has settled.
  always_ff @(posedge clock) begin
    if (reset) data_sync_q <= 2'b11;
    else       data_sync_q <= {data_sync_q[0], ps2_data};
  end

  assign data_sync = data_sync_q[1];
  assign timeout   = (tcnt_q == TIMEOUT_LAST);
  assign state_dbg = state_q;

  // Frame FSM and field registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
    end
  end

  // Next state: one frame field per filtered fall; a timeout abandons the
  // frame from any non-idle state.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    byte_ok   = 1'b0;
    frame_bad = 1'b0;
    case (state_q)
      IDLE: begin
        // A fall with data high is not a start bit; it is simply ignored.
        if (fall && !data_sync) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (timeout) begin
          frame_bad = 1'b1;
          state_d   = IDLE;
        end else if (fall) begin
          shift_d[bit_cnt_q] = data_sync;
          bit_cnt_d          = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) state_d = PARITY;
        end
      end
      PARITY: begin
        if (timeout) begin
          frame_bad = 1'b1;
          state_d   = IDLE;
        end else if (fall) begin
          parity_d = data_sync;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (timeout) begin
          frame_bad = 1'b1;
          state_d   = IDLE;
        end else if (fall) begin
          if (data_sync && odd_parity_ok(shift_q, parity_q)) byte_ok   = 1'b1;
          else                                               frame_bad = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Inter-edge watchdog: clears on every fall inside a frame, held at zero
  // while idle, saturates at the limit until the FSM leaves the frame.
  always_ff @(posedge clock) begin
    if (reset || state_q == IDLE || fall) tcnt_q <= '0;
    else if (!timeout)                    tcnt_q <= tcnt_q + 1'b1;
  end

  // Byte handling: prefixes arm flags, other bytes become key events, and a
  // discarded frame drops any half-built prefix sequence.
  always_ff @(posedge clock) begin
    if (reset) begin
      code          <= '0;
      code_extended <= 1'b0;
      code_released <= 1'b0;
      code_valid    <= 1'b0;
      frame_error   <= 1'b0;
      pending_ext_q <= 1'b0;
      pending_rel_q <= 1'b0;
    end else begin
      code_valid  <= 1'b0;
      frame_error <= 1'b0;
      if (frame_bad) begin
        frame_error   <= 1'b1;
        pending_ext_q <= 1'b0;
        pending_rel_q <= 1'b0;
      end else if (byte_ok) begin
        if (shift_q == PS2_PREFIX_EXT) begin
          pending_ext_q <= 1'b1;
        end else if (shift_q == PS2_PREFIX_BREAK) begin
          pending_rel_q <= 1'b1;
        end else begin
          code          <= shift_q;
          code_extended <= pending_ext_q;
          code_released <= pending_rel_q;
          code_valid    <= 1'b1;
          pending_ext_q <= 1'b0;
          pending_rel_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Bench for ps2_keyboard_receiver: PS/2 bit streams are driven on the pins
// with a scaled-down PS/2 clock; a frame-level model predicts each event and
// the cycle it must appear on, and a compare process checks every cycle.
module tb_ps2_keyboard_receiver;

  localparam int FILTER_LEN = 4;
  localparam int TIMEOUT    = 200;
  // Pin fall to output pulse: 2 sync flops + FILTER_LEN filter + 1 register.
  localparam int LAT        = FILTER_LEN + 3;
  // Last pin fall to timeout pulse.
  localparam int TO_LAT     = LAT + 1 + TIMEOUT;
  localparam int HP         = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clock = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] code;
  logic       code_extended;
  logic       code_released;
  logic       code_valid;
  logic       frame_error;
  logic [1:0] state_dbg;

  ps2_keyboard_receiver #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .ps2_clock     (ps2_clock),
    .ps2_data      (ps2_data),
    .code          (code),
    .code_extended (code_extended),
    .code_released (code_released),
    .code_valid    (code_valid),
    .frame_error   (frame_error),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  // Expected event: {cycle[31:0], kind[1:0] = {error, valid}, ext, rel, code}.
  logic [43:0] exp_q[$];
  logic [43:0] cmp_e;
  logic [7:0]  held_code = 8'h00;
  logic        held_ext  = 1'b0;
  logic        held_rel  = 1'b0;

  // Model prefix state.
  logic m_ext = 1'b0;
  logic m_rel = 1'b0;

  // Burst under construction.
  logic [63:0] b_bits;
  int          b_n;

  // ---------------- scoreboard / compare ----------------
  always @(posedge clock) begin
    #1;
    cyc++;
    total++;
    if (code_valid && frame_error) begin
      bad++;
      $display("FAIL pulse_overlap: cycle %0d code_valid=1 frame_error=1, required never both", cyc);
    end
    if (exp_q.size() > 0 && int'(exp_q[0][43:12]) < cyc) begin
      total++;
      bad++;
      $display("FAIL missed_event: cycle %0d, event kind=%0d code=%h due at cycle %0d never seen",
               cyc, exp_q[0][11:10], exp_q[0][7:0], int'(exp_q[0][43:12]));
      void'(exp_q.pop_front());
    end
    if (code_valid || frame_error) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: cycle %0d valid=%b err=%b code=%h, required no pulse",
                 cyc, code_valid, frame_error, code);
      end else begin
        cmp_e = exp_q.pop_front();
        if (int'(cmp_e[43:12]) != cyc || cmp_e[11:10] != {frame_error, code_valid} ||
            (code_valid && cmp_e[9:0] != {code_extended, code_released, code})) begin
          bad++;
          $display("FAIL event: got cycle %0d valid=%b err=%b ext=%b rel=%b code=%h, required cycle %0d kind=%0d ext=%b rel=%b code=%h",
                   cyc, code_valid, frame_error, code_extended, code_released, code,
                   int'(cmp_e[43:12]), cmp_e[11:10], cmp_e[9], cmp_e[8], cmp_e[7:0]);
        end
        if (cmp_e[10]) begin
          held_ext  = cmp_e[9];
          held_rel  = cmp_e[8];
          held_code = cmp_e[7:0];
        end
      end
    end
    if (reset) begin
      held_ext  = 1'b0;
      held_rel  = 1'b0;
      held_code = 8'h00;
    end
    total++;
    if ({code_extended, code_released, code} !== {held_ext, held_rel, held_code}) begin
      bad++;
      $display("FAIL held_outputs: cycle %0d ext=%b rel=%b code=%h, required ext=%b rel=%b code=%h",
               cyc, code_extended, code_released, code, held_ext, held_rel, held_code);
    end
  end

  // ---------------- model ----------------
  // Frame bits in send order, bit 0 = start.
  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_par,
                                           input logic bad_stop, input logic bad_start);
    return {~bad_stop, (~^d) ^ bad_par, d, bad_start};
  endfunction

  // Parse a burst bit list as a receiver would see it and queue the events.
  // Falls of bit i occur at cycle s + hp + 2*hp*i; the line then idles long
  // enough for any unfinished frame to time out.
  task automatic model_burst(input logic [63:0] bits, input int n, input int s, input int hp);
    int         pos;
    int         fc;
    logic [7:0] d;
    pos = 0;
    while (pos < n) begin
      if (bits[pos]) begin
        pos++;
      end else if (n - pos >= 11) begin
        d  = bits[pos+1 +: 8];
        fc = s + hp + 2 * hp * (pos + 10);
        if (bits[pos+10] && (^{d, bits[pos+9]})) begin
          if (d == 8'hE0) m_ext = 1'b1;
          else if (d == 8'hF0) m_rel = 1'b1;
          else begin
            exp_q.push_back({32'(fc + LAT), 2'b01, m_ext, m_rel, d});
            m_ext = 1'b0;
            m_rel = 1'b0;
          end
        end else begin
          exp_q.push_back({32'(fc + LAT), 2'b10, 10'd0});
          m_ext = 1'b0;
          m_rel = 1'b0;
        end
        pos += 11;
      end else begin
        fc = s + hp + 2 * hp * (n - 1);
        exp_q.push_back({32'(fc + TO_LAT), 2'b10, 10'd0});
        m_ext = 1'b0;
        m_rel = 1'b0;
        pos   = n;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int k);
    repeat (k) @(negedge clock);
  endtask

  task automatic clr();
    b_bits = '1;
    b_n    = 0;
  endtask

  task automatic add_frame(input logic [10:0] f, input int len);
    for (int i = 0; i < len; i++) begin
      b_bits[b_n] = f[i];
      b_n++;
    end
  endtask

  task automatic drive_burst(input int hp, input logic use_model);
    int s;
    @(negedge clock);
    s = cyc;
    if (use_model) model_burst(b_bits, b_n, s, hp);
    for (int i = 0; i < b_n; i++) begin
      ps2_data = b_bits[i];
      repeat (hp) @(negedge clock);
      ps2_clock = 1'b0;
      repeat (hp) @(negedge clock);
      ps2_clock = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send(input int hp);
    drive_burst(hp, 1'b1);
    idle(TO_LAT + 20);
  endtask

  task automatic send_byte(input logic [7:0] d);
    clr();
    add_frame(mk_frame(d, 1'b0, 1'b0, 1'b0), 11);
    send(HP);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    exp_q.delete();
    m_ext = 1'b0;
    m_rel = 1'b0;
    idle(3);
    reset = 1'b0;
    idle(2);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic chk_key(input string name, input logic [7:0] c, input logic e, input logic r);
    chk(name, {22'd0, code_extended, code_released, code}, {22'd0, e, r, c});
  endtask

  // ---------------- stimulus ----------------
  int         nf;
  int         hp_r;
  int         sel;
  int         len;
  logic [7:0] rd;

  initial begin
    do_reset();
    chk("reset_outputs", {21'd0, code_valid, frame_error, code_extended, code_released, code},
        32'd0);
    chk("reset_state", {30'd0, state_dbg}, 32'd0);

    // Make 0x1C.
    send_byte(8'h1C);
    chk_key("make_1c", 8'h1C, 1'b0, 1'b0);

    // Break F0 1C.
    clr();
    add_frame(mk_frame(8'hF0, 1'b0, 1'b0, 1'b0), 11);
    add_frame(mk_frame(8'h1C, 1'b0, 1'b0, 1'b0), 11);
    send(HP);
    chk_key("break_1c", 8'h1C, 1'b0, 1'b1);

    // E0 75, then E0 F0 75.
    clr();
    add_frame(mk_frame(8'hE0, 1'b0, 1'b0, 1'b0), 11);
    add_frame(mk_frame(8'h75, 1'b0, 1'b0, 1'b0), 11);
    send(HP);
    chk_key("ext_make_75", 8'h75, 1'b1, 1'b0);
    clr();
    add_frame(mk_frame(8'hE0, 1'b0, 1'b0, 1'b0), 11);
    add_frame(mk_frame(8'hF0, 1'b0, 1'b0, 1'b0), 11);
    add_frame(mk_frame(8'h75, 1'b0, 1'b0, 1'b0), 11);
    send(HP);
    chk_key("ext_break_75", 8'h75, 1'b1, 1'b1);

    // Bad parity, then bad stop: error pulse, code holds.
    clr();
    add_frame(mk_frame(8'h1C, 1'b1, 1'b0, 1'b0), 11);
    send(HP);
    chk_key("bad_parity_hold", 8'h75, 1'b1, 1'b1);
    clr();
    add_frame(mk_frame(8'h1C, 1'b0, 1'b1, 1'b0), 11);
    send(HP);
    chk_key("bad_stop_hold", 8'h75, 1'b1, 1'b1);

    // F0, then a frame with a bad start, then 1C: the prefix is gone.
    send_byte(8'hF0);
    clr();
    add_frame(mk_frame(8'h1C, 1'b0, 1'b0, 1'b1), 11);
    send(HP);
    send_byte(8'h1C);
    chk_key("bad_start_clears_rel", 8'h1C, 1'b0, 1'b0);

    // Timeout after 5 data bits, then a clean 0x29.
    clr();
    add_frame(mk_frame(8'h29, 1'b0, 1'b0, 1'b0), 6);
    send(HP);
    chk("timeout_idle", {30'd0, state_dbg}, 32'd0);
    send_byte(8'h29);
    chk_key("after_timeout_29", 8'h29, 1'b0, 1'b0);

    // Glitch on ps2_clock shorter than the filter, with data low.
    @(negedge clock);
    ps2_data  = 1'b0;
    ps2_clock = 1'b0;
    idle(FILTER_LEN - 1);
    ps2_clock = 1'b1;
    idle(10);
    ps2_data = 1'b1;
    chk("glitch_idle", {30'd0, state_dbg}, 32'd0);
    idle(TO_LAT + 20);
    send_byte(8'h1C);
    chk_key("after_glitch_1c", 8'h1C, 1'b0, 1'b0);

    // F0, then reset in the middle of a frame, then 1C without the break flag.
    send_byte(8'hF0);
    clr();
    add_frame(mk_frame(8'h5A, 1'b0, 1'b0, 1'b0), 4);
    drive_burst(HP, 1'b0);
    do_reset();
    chk("reset_mid_frame_code", {24'd0, code}, 32'd0);
    send_byte(8'h1C);
    chk_key("after_reset_1c", 8'h1C, 1'b0, 1'b0);

    // Random bursts of prefixes, keys, corrupted and truncated frames.
    for (int r = 0; r < 25; r++) begin
      nf   = $urandom_range(1, 3);
      hp_r = $urandom_range(10, 20);
      clr();
      for (int k = 0; k < nf; k++) begin
        sel = $urandom_range(0, 9);
        if (sel < 2)      rd = 8'hE0;
        else if (sel < 4) rd = 8'hF0;
        else              rd = 8'($urandom_range(0, 255));
        len = 11;
        if (k == nf - 1 && $urandom_range(0, 7) == 0) len = $urandom_range(2, 10);
        add_frame(mk_frame(rd, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                           $urandom_range(0, 11) == 0), len);
      end
      send(hp_r);
    end

    idle(20);
    chk("events_outstanding", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
